// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared types and helpers for the iterative FFT engine
package fft_pkg;

  typedef enum logic [1:0] {ST_LOAD, ST_COMPUTE, ST_UNLOAD} state_t;

  function automatic int bitrev(input int n, input int bits);
    int r;
    r = 0;
    for (int i = 0; i < 16; i++) begin
      if (i < bits) r = (r << 1) | ((n >> i) & 1);
    end
    return r;
  endfunction

  function automatic int round_away(input real v);
    if (v >= 0.0) return $rtoi(v + 0.5);
    else return -$rtoi(0.5 - v);
  endfunction

  // Elaboration-time only: returns re (im=0) or im (im=1) of W_N^k scaled by 2^(tw-2).
  function automatic int twiddle(input int k, input int n_log2, input int tw, input bit im);
    real ang, scale, v;
    ang   = 2.0 * 3.14159265358979323846 * real'(k) / real'(1 << n_log2);
    scale = real'(1 << (tw - 2));
    v     = im ? -$sin(ang) * scale : $cos(ang) * scale;
    return round_away(v);
  endfunction

  function automatic int saturate(input int v, input int dw);
    int hi, lo;
    hi = (1 << (dw - 1)) - 1;
    lo = -(1 << (dw - 1));
    if (v > hi) return hi;
    else if (v < lo) return lo;
    else return v;
  endfunction

endpackage

// File: rtl/fft_iter_if.sv
// rtl/fft_iter_if.sv - sample-in / bin-out stream bundle of the FFT engine
interface fft_iter_if #(
  parameter int DW = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_re;
  logic signed [DW-1:0] in_im;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_re;
  logic signed [DW-1:0] out_im;
  logic                 out_last;

  modport master (
    output in_valid, in_re, in_im, out_ready,
    input  in_ready, out_valid, out_re, out_im, out_last
  );

  modport slave (
    input  in_valid, in_re, in_im, out_ready,
    output in_ready, out_valid, out_re, out_im, out_last
  );
endinterface

// File: rtl/fft_bfly.sv
// rtl/fft_bfly.sv - combinational radix-2 DIT butterfly with halving and saturation
module fft_bfly
  import fft_pkg::*;
#(
  parameter int DW = 8,
  parameter int TW = 8
) (
  input  logic signed [DW-1:0] a_re,
  input  logic signed [DW-1:0] a_im,
  input  logic signed [DW-1:0] b_re,
  input  logic signed [DW-1:0] b_im,
  input  logic signed [TW-1:0] w_re,
  input  logic signed [TW-1:0] w_im,
  output logic signed [DW-1:0] ao_re,
  output logic signed [DW-1:0] ao_im,
  output logic signed [DW-1:0] bo_re,
  output logic signed [DW-1:0] bo_im
);
  int t_re, t_im;

  always_comb begin
    t_re  = (int'(b_re) * int'(w_re) - int'(b_im) * int'(w_im)) >>> (TW - 2);
    t_im  = (int'(b_re) * int'(w_im) + int'(b_im) * int'(w_re)) >>> (TW - 2);
    ao_re = DW'(saturate((int'(a_re) + t_re) >>> 1, DW));
    ao_im = DW'(saturate((int'(a_im) + t_im) >>> 1, DW));
    bo_re = DW'(saturate((int'(a_re) - t_re) >>> 1, DW));
    bo_im = DW'(saturate((int'(a_im) - t_im) >>> 1, DW));
  end
endmodule

// File: rtl/fft_iter.sv
// rtl/fft_iter.sv - iterative in-place radix-2 FFT: bit-reversed load, N_LOG2 stages, natural-order unload
module fft_iter
  import fft_pkg::*;
#(
  parameter int N_LOG2 = 3,
  parameter int DW     = 8,
  parameter int TW     = 8
) (
  input  logic       clk,
  input  logic       rst,
  fft_iter_if.slave  s,
  output logic       busy
);
  localparam int N   = 1 << N_LOG2;
  localparam int AW  = N_LOG2;
  localparam int TWA = N_LOG2 - 1;

  state_t            state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic [3:0]        stage_q, stage_d;
  logic [TWA-1:0]    j_q, j_d;

  logic signed [DW-1:0] mem_re_q [N];
  logic signed [DW-1:0] mem_im_q [N];
  logic signed [TW-1:0] rom_re [N/2];
  logic signed [TW-1:0] rom_im [N/2];

  for (genvar k = 0; k < N/2; k++) begin : g_rom
    localparam int WRE = twiddle(k, N_LOG2, TW, 1'b0);
    localparam int WIM = twiddle(k, N_LOG2, TW, 1'b1);
    assign rom_re[k] = TW'(WRE);
    assign rom_im[k] = TW'(WIM);
  end

  logic [AW-1:0]  top_addr, bot_addr, load_addr;
  logic [TWA-1:0] tw_idx;
  int             s_i, j_i, half_i, top_i;

  always_comb begin
    s_i       = int'(stage_q);
    j_i       = int'(j_q);
    half_i    = 1 << s_i;
    top_i     = ((j_i >> s_i) << (s_i + 1)) + (j_i & (half_i - 1));
    top_addr  = AW'(top_i);
    bot_addr  = AW'(top_i + half_i);
    tw_idx    = TWA'((j_i & (half_i - 1)) << (N_LOG2 - 1 - s_i));
    load_addr = AW'(bitrev(int'(cnt_q), N_LOG2));
  end

  logic signed [DW-1:0] ao_re, ao_im, bo_re, bo_im;

  fft_bfly #(.DW(DW), .TW(TW)) u_bfly (
    .a_re (mem_re_q[top_addr]),
    .a_im (mem_im_q[top_addr]),
    .b_re (mem_re_q[bot_addr]),
    .b_im (mem_im_q[bot_addr]),
    .w_re (rom_re[tw_idx]),
    .w_im (rom_im[tw_idx]),
    .ao_re(ao_re),
    .ao_im(ao_im),
    .bo_re(bo_re),
    .bo_im(bo_im)
  );

  logic in_fire, out_fire, last_bfly, last_cnt;
  assign in_fire   = s.in_valid && s.in_ready;
  assign out_fire  = s.out_valid && s.out_ready;
  assign last_cnt  = (cnt_q == AW'(N - 1));
  assign last_bfly = (stage_q == 4'(N_LOG2 - 1)) && (j_q == '1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_LOAD;
      cnt_q   <= '0;
      stage_q <= '0;
      j_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      j_q     <= j_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOAD:    if (in_fire && last_cnt) state_d = ST_COMPUTE;
      ST_COMPUTE: if (last_bfly) state_d = ST_UNLOAD;
      ST_UNLOAD:  if (out_fire && last_cnt) state_d = ST_LOAD;
      default:    state_d = ST_LOAD;
    endcase
  end

  // The sample counter doubles as the unload address; both wrap to 0 at N.
  always_comb begin
    cnt_d   = cnt_q;
    stage_d = stage_q;
    j_d     = j_q;
    case (state_q)
      ST_LOAD:   if (in_fire) cnt_d = cnt_q + 1'b1;
      ST_COMPUTE: begin
        j_d = j_q + 1'b1;
        if (j_q == '1) stage_d = last_bfly ? 4'd0 : stage_q + 4'd1;
      end
      ST_UNLOAD: if (out_fire) cnt_d = cnt_q + 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    s.in_ready  = (state_q == ST_LOAD);
    s.out_valid = (state_q == ST_UNLOAD);
    busy        = (state_q != ST_LOAD);
    s.out_last  = s.out_valid && last_cnt;
    s.out_re    = s.out_valid ? mem_re_q[cnt_q] : '0;
    s.out_im    = s.out_valid ? mem_im_q[cnt_q] : '0;
  end

  always_ff @(posedge clk) begin
    if (in_fire) begin
      mem_re_q[load_addr] <= s.in_re;
      mem_im_q[load_addr] <= s.in_im;
    end else if (state_q == ST_COMPUTE) begin
      mem_re_q[top_addr] <= ao_re;
      mem_im_q[top_addr] <= ao_im;
      mem_re_q[bot_addr] <= bo_re;
      mem_im_q[bot_addr] <= bo_im;
    end
  end
endmodule

// File: tb/tb_fft_iter.sv
// tb/tb_fft_iter.sv - scoreboard bench for fft_iter (8-point frames plus a 16-point latency run)
module tb_fft_iter;
  logic clk = 1'b0;
  logic rst;
  logic busy8, busy16;
  always #5 clk = ~clk;

  fft_iter_if #(.DW(8)) bus8 ();
  fft_iter_if #(.DW(8)) bus16 ();

  fft_iter #(.N_LOG2(3), .DW(8), .TW(8)) dut8 (
    .clk(clk), .rst(rst), .s(bus8), .busy(busy8)
  );
  fft_iter #(.N_LOG2(4), .DW(8), .TW(8)) dut16 (
    .clk(clk), .rst(rst), .s(bus16), .busy(busy16)
  );

  typedef struct {
    int re;
    int im;
    bit last;
    int tol;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   xr[16];
  int   xi[16];
  bit   bp_mode  = 1'b0;

  task automatic check(input string name, input int act, input int req, input int tol);
    n_checks++;
    if (act < req - tol || act > req + tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (tol %0d)", name, act, req, tol);
    end
  endtask

  task automatic push_bin(input int re, input int im, input bit last, input int tol);
    exp_t e;
    e.re = re; e.im = im; e.last = last; e.tol = tol;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor for the 8-point engine.
  initial begin
    exp_t e;
    bit   prev_stall = 1'b0;
    int   p_re = 0, p_im = 0, p_last = 0, bidx = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_re_stable", bus8.out_re, p_re, 0);
          check("stall_im_stable", bus8.out_im, p_im, 0);
          check("stall_last_stable", bus8.out_last, p_last, 0);
        end
        if (bus8.out_valid) begin
          check("in_ready_low_while_unloading", bus8.in_ready, 0, 0);
        end else begin
          check("idle_out_re_zero", bus8.out_re, 0, 0);
          check("idle_out_im_zero", bus8.out_im, 0, 0);
        end
        if (bus8.out_valid && bus8.out_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_bin: got (%0d,%0d), required no output", bus8.out_re, bus8.out_im);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("bin%0d_re", bidx), bus8.out_re, e.re, e.tol);
            check($sformatf("bin%0d_im", bidx), bus8.out_im, e.im, e.tol);
            check($sformatf("bin%0d_last", bidx), bus8.out_last, int'(e.last), 0);
            bidx = e.last ? 0 : bidx + 1;
          end
        end
        prev_stall = bus8.out_valid && !bus8.out_ready;
        p_re   = bus8.out_re;
        p_im   = bus8.out_im;
        p_last = bus8.out_last;
      end
    end
  end

  initial begin
    bus8.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus8.out_ready = bp_mode ? ~bus8.out_ready : 1'b1;
    end
  end

  task automatic load8();
    for (int n = 0; n < 8; n++) begin
      @(posedge clk);
      #1;
      bus8.in_valid = 1'b1;
      bus8.in_re = 8'(xr[n]);
      bus8.in_im = 8'(xi[n]);
      @(negedge clk);
      check("load_in_ready", bus8.in_ready, 1, 0);
    end
    @(posedge clk);
    // Junk offered while computing must be ignored.
    #1;
    bus8.in_re = 8'sd99;
    bus8.in_im = -8'sd99;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    bus8.in_valid = 1'b0;
  endtask

  task automatic drain8(input string name);
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 200) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got %0d bins outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    @(negedge clk);
    check({name, "_in_ready_after"}, bus8.in_ready, 1, 0);
    check({name, "_busy_after"}, busy8, 0, 0);
  endtask

  task automatic clear_x();
    for (int n = 0; n < 16; n++) begin
      xr[n] = 0;
      xi[n] = 0;
    end
  endtask

  initial begin
    int bp_re[8];
    int bp_im[8];
    int n;
    bit seen;
    bp_re = '{8, 5, 0, -6, -8, -6, 0, 6};
    bp_im = '{0, -6, -8, -6, 0, 6, 8, 6};
    rst = 1'b1;
    bus8.in_valid = 1'b0;  bus8.in_re = '0;  bus8.in_im = '0;
    bus16.in_valid = 1'b0; bus16.in_re = '0; bus16.in_im = '0;
    bus16.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", bus8.in_ready, 1, 0);
    check("reset_out_valid", bus8.out_valid, 0, 0);
    check("reset_out_last", bus8.out_last, 0, 0);
    check("reset_busy", busy8, 0, 0);
    check("reset_out_re", bus8.out_re, 0, 0);

    clear_x();
    xr[0] = 64;
    for (int k = 0; k < 8; k++) push_bin(8, 0, k == 7, 0);
    load8();
    drain8("impulse");

    clear_x();
    for (int k = 0; k < 8; k++) xr[k] = 16;
    for (int k = 0; k < 8; k++) push_bin(k == 0 ? 16 : 0, 0, k == 7, 0);
    load8();
    drain8("dc");

    clear_x();
    for (int k = 0; k < 8; k++) xr[k] = (k % 2 == 0) ? 64 : -64;
    for (int k = 0; k < 8; k++) push_bin(k == 4 ? 64 : 0, 0, k == 7, 1);
    load8();
    drain8("nyquist");

    // Delayed impulse x[1]=64 gives eight distinct bins, so drops or repeats show up.
    clear_x();
    xr[1] = 64;
    for (int k = 0; k < 8; k++) push_bin(bp_re[k], bp_im[k], k == 7, 0);
    bp_mode = 1'b1;
    load8();
    drain8("backpressure");
    bp_mode = 1'b0;

    clear_x();
    xr[0] = 64;
    load8();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midreset_in_ready", bus8.in_ready, 1, 0);
    check("midreset_out_valid", bus8.out_valid, 0, 0);
    check("midreset_busy", busy8, 0, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 8; k++) push_bin(8, 0, k == 7, 0);
    load8();
    drain8("after_reset");

    // 16-point latency: out_valid is first seen in cycle c+33 after accept edge c.
    for (int k = 0; k < 16; k++) begin
      @(posedge clk);
      #1;
      bus16.in_valid = 1'b1;
      bus16.in_re = (k == 0) ? 8'sd64 : 8'sd0;
      bus16.in_im = '0;
    end
    @(posedge clk);
    #1 bus16.in_valid = 1'b0;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      check("lat16_busy", busy16, 1, 0);
      seen = bus16.out_valid;
    end
    check("lat16_first_valid_cycle", n, 33, 0);
    n = 0;
    while (bus16.out_valid && n < 40) begin
      n++;
      check("lat16_bin_re", bus16.out_re, 4, 0);
      check("lat16_bin_im", bus16.out_im, 0, 0);
      check("lat16_last", bus16.out_last, int'(n == 16), 0);
      @(negedge clk);
    end
    check("lat16_bin_count", n, 16, 0);
    check("lat16_in_ready_after", bus16.in_ready, 1, 0);
    check("lat16_busy_after", busy16, 0, 0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got simulation still running, required completion");
    $fatal(1);
  end
endmodule
